// File: rtl/lm_pkg.sv
// Shared constants for the LED-manager scheduler: display tags, FSM state encoding
// and source indices used by the one-hot grant.
package lm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_LATCH = 2'd2,
        ST_SHOW  = 2'd3
    } lm_state_e;

    localparam logic [1:0] LM_TAG_NONE  = 2'b00;
    localparam logic [1:0] LM_TAG_DATA  = 2'b01;
    localparam logic [1:0] LM_TAG_UERR  = 2'b10;
    localparam logic [1:0] LM_TAG_CMERR = 2'b11;

    // Bit positions inside the one-hot grant vector
    localparam int LM_SRC_DATA  = 0;
    localparam int LM_SRC_UERR  = 1;
    localparam int LM_SRC_CMERR = 2;
    localparam int LM_NUM_SRC   = 3;

    function automatic logic [1:0] lm_grant_tag(input logic [LM_NUM_SRC-1:0] grant);
        logic [1:0] tag;
        tag = LM_TAG_NONE;
        if (grant[LM_SRC_DATA])  tag = LM_TAG_DATA;
        if (grant[LM_SRC_UERR])  tag = LM_TAG_UERR;
        if (grant[LM_SRC_CMERR]) tag = LM_TAG_CMERR;
        return tag;
    endfunction

endpackage

// File: rtl/lm_hold_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Load takes priority over decrement, and the count never wraps below zero.
module lm_hold_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/lm_led_scheduler.sv
// Time-shares the board LEDs among the UART data, UART error and CM error FIFOs.
// Optional error blink is built only when LM_BLINK_EN is defined.
module lm_led_scheduler
    import lm_pkg::*;
#(
    parameter int WIDTH_PAYLOAD = 8,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int BLINK_CYCLES  = 12_500_000,
    localparam int WIDTH_LEDS   = WIDTH_PAYLOAD + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     UART_data_debug_switch,
    input  logic [WIDTH_PAYLOAD-1:0] UART_data_rd_data,
    input  logic                     UART_data_fifo_empty,
    output logic                     UART_data_rd_en,
    input  logic [WIDTH_PAYLOAD-1:0] UART_err_rd_data,
    input  logic                     UART_err_fifo_empty,
    output logic                     UART_err_rd_en,
    input  logic [WIDTH_PAYLOAD-1:0] CM_err_rd_data,
    input  logic                     CM_err_fifo_empty,
    output logic                     CM_err_rd_en,
    output logic [WIDTH_LEDS-1:0]    leds,
    output logic                     busy,
    output lm_state_e                state_dbg
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    // Handshake: a FIFO entry is consumed by a single-cycle rd_en pulse in POP;
    // its rd_data is taken in the following LATCH cycle. There is no back-pressure.

    lm_state_e               state_q, state_d;
    logic [LM_NUM_SRC-1:0]   grant_q, grant_d, arb;
    logic                    rr_q, rr_d;          // 0: prefer UART error, 1: prefer CM error
    logic [WIDTH_LEDS-1:0]   leds_q;
    logic [WIDTH_PAYLOAD-1:0] sel_data;
    logic                    uerr_req, cm_req, data_req;
    logic                    hold_load, hold_en, hold_done;

    // Errors only compete when the debug switch is off
    assign uerr_req = !UART_err_fifo_empty && !UART_data_debug_switch;
    assign cm_req   = !CM_err_fifo_empty && !UART_data_debug_switch;
    assign data_req = !UART_data_fifo_empty;

    always_comb begin
        arb = '0;
        if (uerr_req && cm_req) begin
            if (rr_q) arb[LM_SRC_CMERR] = 1'b1;
            else      arb[LM_SRC_UERR]  = 1'b1;
        end else if (uerr_req) begin
            arb[LM_SRC_UERR] = 1'b1;
        end else if (cm_req) begin
            arb[LM_SRC_CMERR] = 1'b1;
        end else if (data_req) begin
            arb[LM_SRC_DATA] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        hold_load = 1'b0;
        hold_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb != '0) begin
                    state_d = ST_POP;
                    grant_d = arb;
                    if (arb[LM_SRC_UERR])  rr_d = 1'b1;
                    if (arb[LM_SRC_CMERR]) rr_d = 1'b0;
                end
            end
            ST_POP:   state_d = ST_LATCH;
            ST_LATCH: begin
                state_d   = ST_SHOW;
                hold_load = 1'b1;
            end
            ST_SHOW: begin
                if (hold_done) state_d = ST_IDLE;
                else           hold_en = 1'b1;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        sel_data = UART_data_rd_data;
        if (grant_q[LM_SRC_UERR])  sel_data = UART_err_rd_data;
        if (grant_q[LM_SRC_CMERR]) sel_data = CM_err_rd_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            leds_q <= '0;
        end else if (state_q == ST_LATCH) begin
            leds_q <= {lm_grant_tag(grant_q), sel_data};
        end
    end

    lm_hold_timer #(.WIDTH(HOLD_W)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .en       (hold_en),
        .done     (hold_done)
    );

    assign UART_data_rd_en = (state_q == ST_POP) && grant_q[LM_SRC_DATA];
    assign UART_err_rd_en  = (state_q == ST_POP) && grant_q[LM_SRC_UERR];
    assign CM_err_rd_en    = (state_q == ST_POP) && grant_q[LM_SRC_CMERR];
    assign busy            = (state_q != ST_IDLE);
    assign state_dbg       = state_q;

`ifdef LM_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYCLES - 1);

    logic blink_on_q, blink_load, blink_done;

    // Reload at every half-period boundary so the phase keeps alternating for any hold length
    assign blink_load = (state_q == ST_LATCH) || ((state_q == ST_SHOW) && blink_done);

    lm_hold_timer #(.WIDTH(BLINK_W)) u_blink (
        .clk      (clk),
        .rst      (rst),
        .load     (blink_load),
        .load_val (BLINK_LOAD),
        .en       (state_q == ST_SHOW),
        .done     (blink_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_on_q <= 1'b1;
        end else if (state_q == ST_LATCH) begin
            blink_on_q <= 1'b1;
        end else if ((state_q == ST_SHOW) && blink_done) begin
            blink_on_q <= !blink_on_q;
        end
    end

    // Only error tags (upper tag bit set) blink; tag bits always stay visible
    always_comb begin
        leds = leds_q;
        if ((state_q == ST_SHOW) && !blink_on_q && leds_q[WIDTH_LEDS-1]) begin
            leds[WIDTH_PAYLOAD-1:0] = '0;
        end
    end
`else
    assign leds = leds_q;
`endif

endmodule

// File: tb/tb_lm_led_scheduler.sv
// Directed bench for lm_led_scheduler with HOLD_CYCLES=4, BLINK_CYCLES=2 and small FIFO models.
// Expected blink masking follows LM_BLINK_EN when the bench is built with it.
module tb_lm_led_scheduler;
    import lm_pkg::*;

    localparam int WP    = 8;
    localparam int HOLD  = 4;
    localparam int BLINK = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sw = 1'b0;
    logic [WP-1:0] data_rd = '0, uerr_rd = '0, cm_rd = '0;
    logic          data_empty, uerr_empty, cm_empty;
    logic          data_rd_en, uerr_rd_en, cm_rd_en;
    logic [WP+1:0] leds;
    logic          busy;
    lm_state_e     state_dbg;

    int vec_cnt = 0;
    int mis_cnt = 0;

    logic [WP-1:0] mem [3][64];
    int push_cnt [3] = '{0, 0, 0};
    int pop_cnt  [3] = '{0, 0, 0};

    typedef struct {
        int          src;
        logic [7:0]  payload;
        logic        sw;
        logic [9:0]  exp_leds;
    } vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

    lm_led_scheduler #(
        .WIDTH_PAYLOAD (WP),
        .HOLD_CYCLES   (HOLD),
        .BLINK_CYCLES  (BLINK)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .UART_data_debug_switch (sw),
        .UART_data_rd_data      (data_rd),
        .UART_data_fifo_empty   (data_empty),
        .UART_data_rd_en        (data_rd_en),
        .UART_err_rd_data       (uerr_rd),
        .UART_err_fifo_empty    (uerr_empty),
        .UART_err_rd_en         (uerr_rd_en),
        .CM_err_rd_data         (cm_rd),
        .CM_err_fifo_empty      (cm_empty),
        .CM_err_rd_en           (cm_rd_en),
        .leds                   (leds),
        .busy                   (busy),
        .state_dbg              (state_dbg)
    );

    // FIFO models: read data appears the cycle after rd_en
    assign data_empty = (push_cnt[0] == pop_cnt[0]);
    assign uerr_empty = (push_cnt[1] == pop_cnt[1]);
    assign cm_empty   = (push_cnt[2] == pop_cnt[2]);

    always @(posedge clk) begin
        if (data_rd_en && !data_empty) begin
            data_rd    <= mem[0][pop_cnt[0]];
            pop_cnt[0] <= pop_cnt[0] + 1;
        end
        if (uerr_rd_en && !uerr_empty) begin
            uerr_rd    <= mem[1][pop_cnt[1]];
            pop_cnt[1] <= pop_cnt[1] + 1;
        end
        if (cm_rd_en && !cm_empty) begin
            cm_rd      <= mem[2][pop_cnt[2]];
            pop_cnt[2] <= pop_cnt[2] + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int src, input logic [WP-1:0] val);
        mem[src][push_cnt[src]] = val;
        push_cnt[src]++;
    endtask

    function automatic logic any_rd_en();
        return data_rd_en | uerr_rd_en | cm_rd_en;
    endfunction

    // Advance one cycle; every pop seen is checked for one-hotness and a non-empty source
    task automatic step();
        @(negedge clk);
        if (any_rd_en()) begin
            check("rd_en_onehot", 32'($countones({data_rd_en, uerr_rd_en, cm_rd_en})), 1);
            check("rd_en_while_empty",
                  {31'd0, (data_rd_en & data_empty) | (uerr_rd_en & uerr_empty) | (cm_rd_en & cm_empty)}, 0);
        end
    endtask

    task automatic wait_pop(output int waited);
        waited = 0;
        do begin
            step();
            waited++;
        end while (!any_rd_en() && waited < 20);
    endtask

    // Expects a pop on the very next cycle, then a HOLD-cycle display and a return to IDLE
    task automatic expect_show(input logic [9:0] exp, input logic tog);
        int          waited;
        logic [2:0]  exp_en;
        logic [9:0]  e;
        wait_pop(waited);
        check("pop_latency", waited, 1);
        if (!any_rd_en()) return;
        case (exp[9:8])
            2'b01:   exp_en = 3'b001;
            2'b10:   exp_en = 3'b010;
            default: exp_en = 3'b100;
        endcase
        check("grant_source", {29'd0, cm_rd_en, uerr_rd_en, data_rd_en}, {29'd0, exp_en});
        check("state_pop", state_dbg, ST_POP);
        step();
        check("state_latch", state_dbg, ST_LATCH);
        for (int i = 0; i < HOLD; i++) begin
            if (tog && (i == 1 || i == 2)) sw = ~sw;
            step();
            e = exp;
`ifdef LM_BLINK_EN
            if (exp[9] && ((i / BLINK) % 2 == 1)) e = {exp[9:8], 8'h00};
`endif
            check("leds_show", e == e ? leds : leds, e);
            check("busy_show", busy, 1);
        end
        step();
        check("leds_retained", leds, exp);
        check("busy_idle", busy, 0);
    endtask

    task automatic expect_quiet(input int cycles, input logic [9:0] exp_leds);
        for (int i = 0; i < cycles; i++) begin
            step();
            check("no_pop", any_rd_en(), 0);
            check("quiet_busy", busy, 0);
            check("quiet_leds", leds, exp_leds);
        end
    endtask

    initial begin
        int waited;

        tbl[0] = '{src: 0, payload: 8'hA5, sw: 1'b0, exp_leds: 10'h1A5};
        tbl[1] = '{src: 2, payload: 8'h3C, sw: 1'b0, exp_leds: 10'h33C};
        tbl[2] = '{src: 1, payload: 8'h5A, sw: 1'b0, exp_leds: 10'h25A};
        tbl[3] = '{src: 0, payload: 8'h00, sw: 1'b1, exp_leds: 10'h100};
        tbl[4] = '{src: 2, payload: 8'hC3, sw: 1'b0, exp_leds: 10'h3C3};

        // Reset held with every FIFO non-empty
        push(0, 8'h11);
        push(1, 8'h22);
        push(2, 8'h33);
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_leds", leds, 0);
            check("reset_busy", busy, 0);
            check("reset_rd_en", any_rd_en(), 0);
            check("reset_state", state_dbg, ST_IDLE);
        end
        rst = 1'b1;
        expect_show(10'h222, 1'b0);
        expect_show(10'h333, 1'b0);
        expect_show(10'h111, 1'b0);

        // Single-entry vectors, each pushed while the scheduler is idle
        for (int v = 0; v < 5; v++) begin
            sw = tbl[v].sw;
            push(tbl[v].src, tbl[v].payload);
            expect_show(tbl[v].exp_leds, 1'b0);
        end
        sw = 1'b0;
        expect_quiet(3, 10'h3C3);

        // Round-robin between error sources, data served last
        push(1, 8'h01);
        push(1, 8'h02);
        push(2, 8'h10);
        push(2, 8'h20);
        push(0, 8'hFF);
        expect_show(10'h201, 1'b0);
        expect_show(10'h310, 1'b0);
        expect_show(10'h202, 1'b0);
        expect_show(10'h320, 1'b0);
        expect_show(10'h1FF, 1'b0);
        expect_quiet(3, 10'h1FF);

        // Debug switch: data only, and a mid-SHOW toggle leaves the hold intact
        sw = 1'b1;
        push(1, 8'h77);
        push(2, 8'h88);
        push(0, 8'h44);
        push(0, 8'h55);
        expect_show(10'h144, 1'b1);
        expect_show(10'h155, 1'b0);
        expect_quiet(6, 10'h155);
        sw = 1'b0;
        expect_show(10'h277, 1'b0);
        expect_show(10'h388, 1'b0);

        // Reset during SHOW
        push(0, 8'h9E);
        wait_pop(waited);
        check("pop_before_show_reset", waited, 1);
        step();
        step();
        check("show_before_reset", leds, 10'h19E);
        rst = 1'b0;
        step();
        check("rst_show_leds", leds, 0);
        check("rst_show_busy", busy, 0);
        check("rst_show_state", state_dbg, ST_IDLE);
        rst = 1'b1;
        expect_quiet(6, 10'h000);

        // Reset in the POP cycle: the popped entry is dropped
        push(0, 8'h6B);
        wait_pop(waited);
        check("pop_before_pop_reset", waited, 1);
        rst = 1'b0;
        step();
        check("rst_pop_leds", leds, 0);
        check("rst_pop_busy", busy, 0);
        check("rst_pop_state", state_dbg, ST_IDLE);
        rst = 1'b1;
        expect_quiet(8, 10'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
